// File: rtl/screen_painter.sv
// Full-screen background painter: raster-sweeps the ROM of the requested image
// and drives the VGA plot interface, then strobes a per-image done flag.
module screen_painter #(
  parameter int H_RES    = 160,
  parameter int V_RES    = 120,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int ADDR_W   = 15,
  parameter int COLOUR_W = 3
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                drawStart,
  input  logic                drawMAP1,
  input  logic                drawMAP2,
  input  logic [COLOUR_W-1:0] rom_q_start,
  input  logic [COLOUR_W-1:0] rom_q_map1,
  input  logic [COLOUR_W-1:0] rom_q_map2,
  output logic [ADDR_W-1:0]   rom_addr,
  output logic [X_W-1:0]      vga_x,
  output logic [Y_W-1:0]      vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                vga_plot,
  output logic                drawStartDone,
  output logic                drawMAP1Done,
  output logic                drawMAP2Done,
  output logic                busy
);

  typedef enum logic [2:0] {IDLE, SWEEP, DRAIN, DONE, HOLD} state_t;
  typedef enum logic [1:0] {SEL_START, SEL_MAP1, SEL_MAP2} sel_t;

  state_t              state, state_nxt;
  sel_t                sel;
  logic [X_W-1:0]      x;
  logic [Y_W-1:0]      y;
  logic [ADDR_W-1:0]   addr;
  logic                any_req, last_col, last_row;

  logic                vld_p0;
  logic [X_W-1:0]      x_p0;
  logic [Y_W-1:0]      y_p0;

  function automatic logic [COLOUR_W-1:0] sel_colour(
    input sel_t s, input logic [COLOUR_W-1:0] q_start,
    input logic [COLOUR_W-1:0] q_map1, input logic [COLOUR_W-1:0] q_map2);
    case (s)
      SEL_MAP1: sel_colour = q_map1;
      SEL_MAP2: sel_colour = q_map2;
      default:  sel_colour = q_start;
    endcase
  endfunction

  assign any_req  = drawStart | drawMAP1 | drawMAP2;
  assign last_col = (x == X_W'(H_RES - 1));
  assign last_row = (y == Y_W'(V_RES - 1));
  assign rom_addr = addr;
  assign busy     = (state == SWEEP) || (state == DRAIN);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = SWEEP;
      SWEEP:   if (last_col && last_row) state_nxt = DRAIN;
      DRAIN:   state_nxt = DONE;
      DONE:    state_nxt = HOLD;
      HOLD:    if (!any_req) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control: FSM, raster counters and image select; addr tracks y*H_RES+x incrementally
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      sel   <= SEL_START;
      x     <= '0;
      y     <= '0;
      addr  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (any_req) begin
            if (drawStart)     sel <= SEL_START;
            else if (drawMAP1) sel <= SEL_MAP1;
            else               sel <= SEL_MAP2;
            x    <= '0;
            y    <= '0;
            addr <= '0;
          end
        end
        SWEEP: begin
          if (!(last_col && last_row)) begin
            addr <= addr + 1'b1;
            if (last_col) begin
              x <= '0;
              y <= y + 1'b1;
            end else begin
              x <= x + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Stage p0: coordinates wait alongside the 1-cycle ROM read
  always_ff @(posedge clk) begin
    if (!resetn) vld_p0 <= 1'b0;
    else         vld_p0 <= (state == SWEEP);
  end

  always_ff @(posedge clk) begin
    x_p0 <= x;
    y_p0 <= y;
  end

  // Stage p1: registered plot outputs and done strobes (outputs are cleared on reset)
  always_ff @(posedge clk) begin
    if (!resetn) begin
      vga_plot      <= 1'b0;
      vga_x         <= '0;
      vga_y         <= '0;
      vga_colour    <= '0;
      drawStartDone <= 1'b0;
      drawMAP1Done  <= 1'b0;
      drawMAP2Done  <= 1'b0;
    end else begin
      vga_plot <= vld_p0;
      if (vld_p0) begin
        vga_x      <= x_p0;
        vga_y      <= y_p0;
        vga_colour <= sel_colour(sel, rom_q_start, rom_q_map1, rom_q_map2);
      end
      drawStartDone <= (state == DONE) && (sel == SEL_START);
      drawMAP1Done  <= (state == DONE) && (sel == SEL_MAP1);
      drawMAP2Done  <= (state == DONE) && (sel == SEL_MAP2);
    end
  end

endmodule

// File: tb/tb_screen_painter.sv
// Scoreboard bench for screen_painter: a 4x3 instance for protocol cases and a
// default 160x120 instance for the full-frame case.
module tb_screen_painter;

  localparam int H  = 4;
  localparam int V  = 3;
  localparam int N  = H * V;
  localparam int HL = 160;
  localparam int VL = 120;
  localparam int NL = HL * VL;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // small instance signals
  logic        ds = 0, dm1 = 0, dm2 = 0;
  logic [2:0]  q_start, q_map1, q_map2;
  logic [14:0] rom_addr;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot, done_start, done_map1, done_map2, busy;

  // large instance signals
  logic        l_ds = 0, l_dm1 = 0, l_dm2 = 0;
  logic [2:0]  lq_start, lq_map1, lq_map2;
  logic [14:0] l_rom_addr;
  logic [7:0]  l_x;
  logic [6:0]  l_y;
  logic [2:0]  l_colour;
  logic        l_plot, l_done_start, l_done_map1, l_done_map2, l_busy;

  screen_painter #(.H_RES(H), .V_RES(V)) dut (
    .clk(clk), .resetn(resetn),
    .drawStart(ds), .drawMAP1(dm1), .drawMAP2(dm2),
    .rom_q_start(q_start), .rom_q_map1(q_map1), .rom_q_map2(q_map2),
    .rom_addr(rom_addr), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .vga_plot(vga_plot), .drawStartDone(done_start), .drawMAP1Done(done_map1),
    .drawMAP2Done(done_map2), .busy(busy)
  );

  screen_painter dut_l (
    .clk(clk), .resetn(resetn),
    .drawStart(l_ds), .drawMAP1(l_dm1), .drawMAP2(l_dm2),
    .rom_q_start(lq_start), .rom_q_map1(lq_map1), .rom_q_map2(lq_map2),
    .rom_addr(l_rom_addr), .vga_x(l_x), .vga_y(l_y), .vga_colour(l_colour),
    .vga_plot(l_plot), .drawStartDone(l_done_start), .drawMAP1Done(l_done_map1),
    .drawMAP2Done(l_done_map2), .busy(l_busy)
  );

  // which: 1 = start, 2 = map1, 4 = map2 (matches {map2,map1,start} done bits)
  function automatic int rom_fn(input int which, input int a);
    logic [2:0] b;
    b = a[2:0];
    case (which)
      1:       rom_fn = int'(b ^ 3'b101);
      2:       rom_fn = int'(b);
      default: rom_fn = int'(b ^ 3'b011);
    endcase
  endfunction

  always @(posedge clk) begin
    q_start  <= 3'(rom_fn(1, int'(rom_addr)));
    q_map1   <= 3'(rom_fn(2, int'(rom_addr)));
    q_map2   <= 3'(rom_fn(4, int'(rom_addr)));
    lq_start <= 3'(rom_fn(1, int'(l_rom_addr)));
    lq_map1  <= 3'(rom_fn(2, int'(l_rom_addr)));
    lq_map2  <= 3'(rom_fn(4, int'(l_rom_addr)));
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  typedef struct {int edge_n; int x; int y; int col;} pix_t;
  typedef struct {int edge_n; int which;} done_t;
  pix_t  pix_q[$];
  done_t done_q[$];
  pix_t  mp;
  done_t md;
  int    m_which;

  // small-instance monitor; edge_n is the clock edge that samples the output
  always @(negedge clk) begin
    if (vga_plot === 1'b1) begin
      if (pix_q.size() == 0) chk("unexpected_plot", 1, 0);
      else begin
        mp = pix_q.pop_front();
        chk("plot_edge", cyc + 1, mp.edge_n);
        chk("plot_x", int'(vga_x), mp.x);
        chk("plot_y", int'(vga_y), mp.y);
        chk("plot_colour", int'(vga_colour), mp.col);
      end
    end
    m_which = int'({done_map2, done_map1, done_start});
    if (m_which != 0) begin
      if (done_q.size() == 0) chk("unexpected_done", m_which, 0);
      else begin
        md = done_q.pop_front();
        chk("done_edge", cyc + 1, md.edge_n);
        chk("done_sel", m_which, md.which);
      end
    end
  end

  // large-instance monitor
  int l_plots = 0, l_bad = 0, l_lastx = -1, l_lasty = -1, l_maxaddr = -1;
  int l_done_edge = -1, l_done_cnt = 0, l_ex = 0, l_ey = 0, l_other_done = 0;
  always @(negedge clk) begin
    if (l_plot === 1'b1) begin
      if (int'(l_x) != l_ex || int'(l_y) != l_ey ||
          int'(l_colour) != rom_fn(1, l_ey * HL + l_ex)) l_bad++;
      l_plots++;
      l_lastx = int'(l_x);
      l_lasty = int'(l_y);
      if (l_ex == HL - 1) begin l_ex = 0; l_ey++; end
      else l_ex++;
    end
    if (l_busy === 1'b1 && int'(l_rom_addr) > l_maxaddr) l_maxaddr = int'(l_rom_addr);
    if (l_done_start === 1'b1) begin l_done_cnt++; l_done_edge = cyc + 1; end
    if (l_done_map1 === 1'b1 || l_done_map2 === 1'b1) l_other_done++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive a request set (DUT must be IDLE) and load the expected frame.
  task automatic start_frame(input logic s, input logic m1, input logic m2, input int which);
    int c0;
    ds = s; dm1 = m1; dm2 = m2;
    c0 = cyc + 1;
    for (int a = 0; a < N; a++)
      pix_q.push_back('{c0 + 3 + a, a % H, a / H, rom_fn(which, a)});
    done_q.push_back('{c0 + N + 3, which});
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((pix_q.size() != 0 || done_q.size() != 0) && n < budget) begin
      tick(1);
      n++;
    end
    if (n >= budget) begin
      chk("frame_timeout", pix_q.size() + done_q.size(), 0);
      pix_q.delete();
      done_q.delete();
    end
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_rom_addr"}, int'(rom_addr), 0);
    chk({pfx, "_vga_x"}, int'(vga_x), 0);
    chk({pfx, "_vga_y"}, int'(vga_y), 0);
    chk({pfx, "_vga_colour"}, int'(vga_colour), 0);
    chk({pfx, "_vga_plot"}, int'(vga_plot), 0);
    chk({pfx, "_done"}, int'({done_map2, done_map1, done_start}), 0);
    chk({pfx, "_busy"}, int'(busy), 0);
  endtask

  initial begin
    int lc0, n, c0;
    tick(3);
    chk_all_zero("reset");
    chk("reset_l_busy", int'(l_busy), 0);
    resetn = 1'b1;
    tick(2);

    // map1 held; addresses contiguous across the row wrap
    start_frame(1'b0, 1'b1, 1'b0, 2);
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      chk("sweep_rom_addr", int'(rom_addr), i);
      if (i == 0) chk("sweep_busy", int'(busy), 1);
    end
    wait_drain(40);
    dm1 = 1'b0;
    tick(2);

    // start and map2 together, then switched to map1 mid-sweep
    start_frame(1'b1, 1'b0, 1'b1, 1);
    tick(5);
    ds = 1'b0; dm2 = 1'b0; dm1 = 1'b1;
    wait_drain(40);
    dm1 = 1'b0;
    tick(2);

    // map2 held long after done: no redraw until it drops
    start_frame(1'b0, 1'b0, 1'b1, 4);
    wait_drain(40);
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (i % 5 == 4) chk("hold_busy", int'(busy), 0);
    end
    dm2 = 1'b0;
    tick(2);
    start_frame(1'b0, 1'b0, 1'b1, 4);
    wait_drain(40);
    dm2 = 1'b0;
    tick(2);

    // reset during pixel 6, request kept high through and after reset
    start_frame(1'b0, 1'b1, 1'b0, 2);
    c0 = cyc;
    n = 0;
    while (cyc < c0 + 9 && n < 50) begin tick(1); n++; end
    resetn = 1'b0;
    tick(1);
    pix_q.delete();
    done_q.delete();
    chk_all_zero("midreset");
    resetn = 1'b1;
    start_frame(1'b0, 1'b1, 1'b0, 2);
    wait_drain(40);
    dm1 = 1'b0;
    tick(2);

    // full-size frame on the default instance
    l_ds = 1'b1;
    lc0 = cyc + 1;
    n = 0;
    while (l_done_cnt == 0 && n < NL + 200) begin tick(1); n++; end
    l_ds = 1'b0;
    tick(5);
    chk("big_plots", l_plots, NL);
    chk("big_order_colour_errs", l_bad, 0);
    chk("big_last_x", l_lastx, HL - 1);
    chk("big_last_y", l_lasty, VL - 1);
    chk("big_last_addr", l_maxaddr, NL - 1);
    chk("big_done_count", l_done_cnt, 1);
    chk("big_done_latency", l_done_edge - lc0, NL + 3);
    chk("big_other_done", l_other_done, 0);
    chk("small_queue_left", pix_q.size() + done_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
